// File: rtl/redmule_job_dispatcher.sv
// redmule_job_dispatcher: buffers offloaded RedMulE jobs and runs them one at a time through the controller.
// Optional REDMULE_DISPATCH_PERF_EN adds perf_cycles_o (ISSUE..DONE cycle count of the last job).
module redmule_job_dispatcher #(
  parameter int unsigned N_CORES   = 8,
  parameter int unsigned N_CONTEXT = 2,
  parameter int unsigned ID_WIDTH  = 8,
  parameter int unsigned CfgWidth  = 256,
  localparam int unsigned CW = (N_CORES > 1) ? $clog2(N_CORES) : 1,
  localparam int unsigned OW = $clog2(N_CONTEXT + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [CfgWidth-1:0]          push_cfg_i,
  input  logic [CW-1:0]                push_core_i,
  output logic [ID_WIDTH-1:0]          push_id_o,
  output logic                         ctrl_start_o,
  output logic [CfgWidth-1:0]          ctrl_cfg_o,
  input  logic                         ctrl_cfg_cpl_i,
  input  logic                         ctrl_done_i,
  input  logic                         ctrl_busy_i,
  output logic [N_CORES-1:0][1:0]      evt_o,
  output logic [OW-1:0]                occupancy_o,
  output logic [ID_WIDTH-1:0]          running_id_o,
  output logic                         idle_o
`ifdef REDMULE_DISPATCH_PERF_EN
  ,
  output logic [31:0]                  perf_cycles_o
`endif
);
  localparam int unsigned PW = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CFG, RUN, DONE} state_e;
  state_e              state_q;
  logic [CfgWidth-1:0] cfg_mem  [N_CONTEXT];
  logic [CW-1:0]       core_mem [N_CONTEXT];
  logic [ID_WIDTH-1:0] id_mem   [N_CONTEXT];
  logic [PW-1:0]       head_q, tail_q;
  logic [OW-1:0]       occ_q;
  logic [ID_WIDTH-1:0] id_q;
  logic                push, pop, empty;
`ifdef REDMULE_DISPATCH_PERF_EN
  logic [31:0]         cnt_q;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
`endif
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(N_CONTEXT - 1)) ? '0 : p + PW'(1);
  endfunction
  assign empty        = occ_q == '0;
  assign push_ready_o = occ_q < OW'(N_CONTEXT);
  assign push         = push_valid_i & push_ready_o;
  assign pop          = state_q == DONE;
  assign push_id_o    = id_q;
  assign ctrl_start_o = state_q == ISSUE;
  assign ctrl_cfg_o   = empty ? '0 : cfg_mem[head_q];
  assign running_id_o = empty ? '0 : id_mem[head_q];
  assign occupancy_o  = occ_q;
  assign idle_o       = (state_q == IDLE) & empty;
  always_ff @(posedge clk_i) begin
    if (push) begin
      cfg_mem[tail_q]  <= push_cfg_i;
      core_mem[tail_q] <= push_core_i;
      id_mem[tail_q]   <= id_q;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      id_q    <= '0;
      evt_o   <= '0;
`ifdef REDMULE_DISPATCH_PERF_EN
      cnt_q         <= '0;
      perf_cycles_o <= '0;
`endif
    end else if (clear_i) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      id_q    <= '0;
      evt_o   <= '0;
`ifdef REDMULE_DISPATCH_PERF_EN
      cnt_q         <= '0;
      perf_cycles_o <= '0;
`endif
    end else begin
      evt_o <= '0;
      if (push) begin
        tail_q <= nxt(tail_q);
        id_q   <= id_q + ID_WIDTH'(1);
      end
      if (pop) head_q <= nxt(head_q);
      occ_q <= occ_q + OW'(push) - OW'(pop);
`ifdef REDMULE_DISPATCH_PERF_EN
      cnt_q <= ctrl_start_o ? 32'd1 : sat_inc(cnt_q);
      if (pop) perf_cycles_o <= sat_inc(cnt_q);
`endif
      case (state_q)
        IDLE:     if (!empty && !ctrl_busy_i) state_q <= ISSUE;
        ISSUE:    state_q <= WAIT_CFG;
        WAIT_CFG: if (ctrl_cfg_cpl_i) state_q <= RUN;
        RUN:      if (ctrl_done_i) state_q <= DONE;
        default: begin
          state_q                 <= IDLE;
          evt_o[core_mem[head_q]] <= {(occ_q == OW'(1)) && !push, 1'b1};
        end
      endcase
    end
  end
endmodule
